baud_rate_gen: RTL and testbench
================================

Name: baud_rate_gen

Overview:
Parametrised fractional baud-rate generator for the RS232 path, the successor to the fixed 16-bit single-tick generator. It uses a phase accumulator with a runtime-programmable increment and produces three pulses: an oversample tick for the receiver, a bit tick for the transmitter, and a mid-bit sample tick. A phase-sync input lets the RX FSM realign the bit phase on a start-bit edge. The block sits between the system clock and the uart_tx/uart_rx FSMs.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD, 115200, default baud rate.
OVERSAMPLE, 16, oversample ticks per bit; power of two, >= 2.
ACC_WIDTH, 20, accumulator fraction width in bits, range 8..28.
DEFAULT_INC, round(BAUD*OVERSAMPLE*2^ACC_WIDTH / CLK_FREQ), reset value of the increment; evaluates to 38655 for the defaults.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
en  in  1  run enable; when low the accumulator phase is frozen.
sync  in  1  phase restart strobe.
inc_load  in  1  load strobe for inc_in.
inc_in  in  ACC_WIDTH  new increment value.
inc_q  out  ACC_WIDTH  currently active increment.
tick_os  out  1  oversample tick, single-cycle pulse.
tick_mid  out  1  mid-bit tick, single-cycle pulse.
tick_bit  out  1  bit-period tick, single-cycle pulse.

Behaviour:
- Reset (async):
  - acc = 0, os_cnt = 0, inc_q = DEFAULT_INC.
  - tick_os = tick_mid = tick_bit = 0.
- State registers:
  - acc: ACC_WIDTH bits.
  - os_cnt: log2(OVERSAMPLE) bits.
  - inc_q: ACC_WIDTH bits.
  - All outputs are registered.
- Sum: sum = {1'b0, acc} + {1'b0, inc_q}, ACC_WIDTH+1 bits; carry = sum[ACC_WIDTH].
- Per-edge priority, highest first:
  1. sync=1:
     - acc <= 0, os_cnt <= 0, all ticks <= 0.
     - sync overrides en and any carry.
  2. en=1:
     - acc <= sum[ACC_WIDTH-1:0] (fraction wraps modulo 2^ACC_WIDTH, no saturation).
     - tick_os <= carry.
     - If carry: os_cnt <= os_cnt+1, wrapping at OVERSAMPLE.
     - tick_mid <= carry and (os_cnt == OVERSAMPLE/2-1).
     - tick_bit <= carry and (os_cnt == OVERSAMPLE-1).
  3. en=0: acc and os_cnt hold; all ticks <= 0.
- inc_load is independent of sync and en:
  - inc_q <= inc_in.
  - The sum computed in the same cycle uses the old inc_q; the new value applies from the next edge.
  - acc and os_cnt are not disturbed.
- Latency and pulse shape:
  - A tick is high for exactly one cycle, in the cycle after the edge where carry occurred.
  - tick_mid and tick_bit always coincide with a tick_os pulse.
  - They never occur together, because OVERSAMPLE >= 2.
- Boundary cases:
  - inc_q = 0: no ticks ever.
  - Every value of inc_q below 2^ACC_WIDTH is legal, so at most one carry per cycle.
  - After sync, the first tick_mid follows OVERSAMPLE/2 oversample periods later; RX uses it for the start-bit centre.
  - sync and inc_load together: both take effect.
- Long-run tick_os rate = CLK_FREQ * inc_q / 2^ACC_WIDTH. Jitter is at most 1 clk.

Decomposition:
- Package baud_pkg holds:
  - function calc_inc(clk_freq, baud, oversample, acc_width), 64-bit rounded division;
  - clog2 helper;
  - localparam OS_W = clog2(OVERSAMPLE).
- Sub-module baud_os_divider:
  - takes the carry pulse and sync;
  - owns os_cnt;
  - produces tick_mid and tick_bit.
- Accumulator, increment register and tick_os stay in the top module.

Test Plan:
- Reset/default (all parameters default): assert reset mid-run → all ticks 0 immediately, inc_q = 38655 with no clock edge; after release with en=1, tick_os appears within 28 clk.
- Exact rate (ACC_WIDTH=4, OVERSAMPLE=4, load inc=4, sync, then en=1):
  - tick_os high after edges 4, 8, 12, 16, ...;
  - tick_mid after edges 8, 24, ...;
  - tick_bit after edges 16, 32, ...;
  - every pulse 1 cycle wide.
- Fractional rate (ACC_WIDTH=4, inc=6, en=1 for 48 edges after sync): exactly 18 tick_os pulses; gaps of 2 or 3 cycles only.
- Freeze (en=0 for 10 cycles between ticks): no pulses while low; after en returns, the next tick arrives with the remaining phase preserved (same count of enabled edges as without the pause).
- Sync mid-bit (ACC_WIDTH=4, OVERSAMPLE=4, inc=4): assert sync in the same cycle as a carry → no tick next cycle; os_cnt restarts so that tick_mid follows 8 edges later.
- Runtime reload: change inc 4→8 with inc_load → one more period at 4; afterwards tick_os every 2 edges; inc=0 → no ticks for 100 cycles.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared helpers for the fractional baud-rate generator.
//   clog2     : ceiling log2 that can be used in parameter expressions
//   calc_inc  : rounded phase increment for a clock/baud/oversample setting
//   OS_W      : oversample counter width for the default oversample ratio
package baud_pkg;

    localparam int DEF_OVERSAMPLE = 16;

    function automatic int clog2(input longint value);
        int     width;
        longint rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return width;
    endfunction

    // round(baud * oversample * 2^acc_width / clk_freq), done in 64 bits
    // because the numerator overflows 32 bits for normal settings.
    function automatic longint calc_inc(input longint clk_freq,
                                        input longint baud,
                                        input longint oversample,
                                        input int     acc_width);
        longint num;
        num = baud * oversample * (longint'(1) << acc_width);
        return (num + clk_freq / 2) / clk_freq;
    endfunction

    localparam int OS_W = clog2(DEF_OVERSAMPLE);

endpackage

// File: rtl/baud_os_divider.sv
// Divides the oversample carry down to mid-bit and bit-period ticks.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   sync     : phase restart, clears the counter and both ticks
//   carry    : accumulator carry, already qualified by the run enable
//   tick_mid : registered pulse on the carry that closes the first half bit
//   tick_bit : registered pulse on the carry that closes the bit period
module baud_os_divider
    import baud_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sync,
    input  logic carry,
    output logic tick_mid,
    output logic tick_bit
);

    localparam int CNT_W = clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] os_cnt;

    // Counts oversample carries within a bit. OVERSAMPLE is a power of two,
    // so the natural binary wrap of os_cnt is the wrap at OVERSAMPLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            os_cnt   <= '0;
            tick_mid <= 1'b0;
            tick_bit <= 1'b0;
        end else if (sync) begin
            os_cnt   <= '0;
            tick_mid <= 1'b0;
            tick_bit <= 1'b0;
        end else begin
            tick_mid <= carry && (os_cnt == MID_CNT);
            tick_bit <= carry && (os_cnt == LAST_CNT);
            if (carry) begin
                os_cnt <= os_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/baud_rate_gen.sv
// Fractional baud-rate generator: a phase accumulator with a programmable
// increment, producing oversample, mid-bit and bit-period ticks.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   en       : run enable, phase frozen while low
//   sync     : phase restart strobe (start-bit realignment)
//   inc_load : load strobe for inc_in
//   inc_in   : new phase increment
//   inc_q    : currently active increment
//   tick_os  : oversample tick, one-cycle pulse
//   tick_mid : mid-bit tick, one-cycle pulse
//   tick_bit : bit-period tick, one-cycle pulse
module baud_rate_gen
    import baud_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int ACC_WIDTH   = 20,
    parameter int DEFAULT_INC = int'(calc_inc(CLK_FREQ, BAUD, OVERSAMPLE, ACC_WIDTH))
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 inc_load,
    input  logic [ACC_WIDTH-1:0] inc_in,
    output logic [ACC_WIDTH-1:0] inc_q,
    output logic                 tick_os,
    output logic                 tick_mid,
    output logic                 tick_bit
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 step;

    assign sum   = {1'b0, acc} + {1'b0, inc_q};
    assign carry = sum[ACC_WIDTH];
    assign step  = en & carry;

    // Phase accumulator and oversample tick; sync beats en and any carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            tick_os <= 1'b0;
        end else if (sync) begin
            acc     <= '0;
            tick_os <= 1'b0;
        end else if (en) begin
            acc     <= sum[ACC_WIDTH-1:0];
            tick_os <= carry;
        end else begin
            tick_os <= 1'b0;
        end
    end

    // Increment register; the sum above still uses the old value this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q <= ACC_WIDTH'(DEFAULT_INC);
        end else if (inc_load) begin
            inc_q <= inc_in;
        end
    end

    baud_os_divider #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_os_divider (
        .clk     (clk),
        .reset   (reset),
        .sync    (sync),
        .carry   (step),
        .tick_mid(tick_mid),
        .tick_bit(tick_bit)
    );

endmodule

// File: tb/tb_baud_rate_gen.sv
// Testbench for baud_rate_gen: a default-parameter instance for reset
// behaviour and a small instance (ACC_WIDTH=4, OVERSAMPLE=4) for timing.
module tb_baud_rate_gen;

    logic clk;

    // default-parameter instance
    logic        rst_d, en_d, sync_d, load_d;
    logic [19:0] inc_in_d, inc_q_d;
    logic        os_d, mid_d, bit_d;

    // small instance
    logic        rst_s, en_s, sync_s, load_s;
    logic [3:0]  inc_in_s, inc_q_s;
    logic        os_s, mid_s, bit_s;

    int total;
    int bad;

    // reference model of the small instance: unwrapped phase since sync
    longint m_phase;
    int     m_inc;
    logic   m_os, m_mid, m_bit;

    typedef struct packed {
        logic       sync;
        logic       en;
        logic       load;
        logic [3:0] inc;
        logic       os;
        logic       mid;
        logic       tbit;
    } vec_t;

    vec_t vecs [25];

    baud_rate_gen u_dut_def (
        .clk     (clk),
        .reset   (rst_d),
        .en      (en_d),
        .sync    (sync_d),
        .inc_load(load_d),
        .inc_in  (inc_in_d),
        .inc_q   (inc_q_d),
        .tick_os (os_d),
        .tick_mid(mid_d),
        .tick_bit(bit_d)
    );

    baud_rate_gen #(
        .CLK_FREQ   (50000000),
        .BAUD       (115200),
        .OVERSAMPLE (4),
        .ACC_WIDTH  (4),
        .DEFAULT_INC(4)
    ) u_dut_small (
        .clk     (clk),
        .reset   (rst_s),
        .en      (en_s),
        .sync    (sync_s),
        .inc_load(load_s),
        .inc_in  (inc_in_s),
        .inc_q   (inc_q_s),
        .tick_os (os_s),
        .tick_mid(mid_s),
        .tick_bit(bit_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One edge of the reference model: the n-th oversample tick since sync
    // is a mid tick when n mod 4 == 2 and a bit tick when n mod 4 == 0.
    task automatic modelStep(input logic s, input logic e, input logic ld,
                             input logic [3:0] v);
        longint before_n, after_n;
        if (s) begin
            m_phase = 0;
            m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0;
        end else if (e) begin
            before_n = m_phase / 16;
            after_n  = (m_phase + m_inc) / 16;
            m_phase  = m_phase + m_inc;
            m_os  = (after_n != before_n);
            m_mid = m_os && (after_n % 4 == 2);
            m_bit = m_os && (after_n % 4 == 0);
        end else begin
            m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0;
        end
        if (ld) m_inc = int'(v);
    endtask

    // Drive one cycle of small-instance inputs, clock it, sample #1 later.
    task automatic applyStimulus(input logic s, input logic e, input logic ld,
                                 input logic [3:0] v);
        sync_s = s; en_s = e; load_s = ld; inc_in_s = v;
        @(posedge clk);
        modelStep(s, e, ld, v);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eos,
                               input logic emid, input logic ebit,
                               input int einc);
        total++;
        if (os_s !== eos || mid_s !== emid || bit_s !== ebit ||
            int'(inc_q_s) != einc) begin
            bad++;
            $display("[TB] FAIL %s: got os/mid/bit/inc=%b%b%b/%0d want %b%b%b/%0d",
                     name, os_s, mid_s, bit_s, inc_q_s, eos, emid, ebit, einc);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, m_os, m_mid, m_bit, m_inc);
    endtask

    task automatic checkValue(input string name, input longint got,
                              input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        int n, last, gaps_bad, cnt;
        logic found;
        vec_t v;

        total = 0;
        bad   = 0;

        // exact rate with inc=4: os every 4 edges, mid at 8 and 24, bit at 16
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};

        // ---------------- reset of both instances ----------------
        rst_d = 1'b1; en_d = 1'b0; sync_d = 1'b0; load_d = 1'b0; inc_in_d = '0;
        rst_s = 1'b1; en_s = 1'b0; sync_s = 1'b0; load_s = 1'b0; inc_in_s = '0;
        m_phase = 0; m_inc = 4; m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0;
        @(posedge clk);
        #1;
        rst_d = 1'b0;
        rst_s = 1'b0;
        checkOutput("reset_small", 1'b0, 1'b0, 1'b0, 4);
        checkValue("reset_def_inc", longint'(inc_q_d), 38655);

        // default instance: big increment so a tick shows up quickly
        load_d = 1'b1; inc_in_d = 20'd600000;
        @(posedge clk);
        #1;
        load_d = 1'b0;
        checkValue("def_load_inc", longint'(inc_q_d), 600000);
        en_d  = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (os_d) found = 1'b1;
        end
        checkValue("def_tick_seen", longint'(found), 1);

        // async reset while tick_os is high: clears at once, no edge needed
        rst_d = 1'b1;
        #1;
        checkValue("async_ticks", longint'({os_d, mid_d, bit_d}), 0);
        checkValue("async_inc", longint'(inc_q_d), 38655);
        @(posedge clk);
        #1;
        rst_d = 1'b0;
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(posedge clk);
            #1;
            if (os_d) begin
                found = 1'b1;
                n = k;
            end
        end
        checkValue("def_first_os_edge", n, 28);
        en_d = 1'b0;

        // ---------------- exact rate, table driven ----------------
        for (int i = 0; i < 25; i++) begin
            v = vecs[i];
            applyStimulus(v.sync, v.en, v.load, v.inc);
            checkOutput("table", v.os, v.mid, v.tbit, 4);
        end

        // ---------------- fractional rate inc=6 ----------------
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd6);
        checkModel("frac_sync");
        cnt = 0; last = -1; gaps_bad = 0;
        for (int k = 1; k <= 48; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
            checkModel("frac");
            if (os_s) begin
                if (last >= 0 && (k - last < 2 || k - last > 3)) gaps_bad++;
                last = k;
                cnt++;
            end
        end
        checkValue("frac_count", cnt, 18);
        checkValue("frac_gaps", gaps_bad, 0);

        // ---------------- freeze with en=0 ----------------
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd4);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
            checkModel("freeze_pre");
        end
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
            checkModel("freeze_low");
            if (os_s || mid_s || bit_s) cnt++;
        end
        checkValue("freeze_quiet", cnt, 0);
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
            checkModel("freeze_post");
            if (os_s) begin
                found = 1'b1;
                n = k;
            end
        end
        checkValue("freeze_resume_edges", n, 2);

        // ---------------- sync on a carry edge ----------------
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
            checkModel("syncmid_pre");
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkValue("syncmid_no_tick", longint'(os_s), 0);
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 16 && !found; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
            checkModel("syncmid_post");
            if (mid_s) begin
                found = 1'b1;
                n = k;
            end
        end
        checkValue("syncmid_mid_edges", n, 8);

        // ---------------- runtime reload 4 -> 8 -> 0 ----------------
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd8);
        checkOutput("reload_old_inc", 1'b0, 1'b0, 1'b0, 8);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        checkModel("reload_first");
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
            checkModel("reload8");
            if (os_s) cnt++;
        end
        checkValue("reload8_count", cnt, 8);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        checkModel("reload_zero");
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
            if (os_s || mid_s || bit_s) cnt++;
        end
        checkValue("zero_inc_quiet", cnt, 0);

        // ---------------- randomized against the model ----------------
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(15) == 0),
                          ($urandom_range(3) != 0),
                          ($urandom_range(19) == 0),
                          4'($urandom_range(15)));
            checkModel("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
